// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : CPU request/response and data-memory bus bundle for
//               mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataW;
    logic        mem_enaR;
    logic        mem_enaW;
    logic [31:0] mem_data_out;

    // Unit side
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_data_out,
        output stall, rsp_valid, rsp_err, rsp_rdata,
        output mem_addr, mem_dataW, mem_enaR, mem_enaW
    );

    // CPU plus memory side
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_data_out,
        input  stall, rsp_valid, rsp_err, rsp_rdata,
        input  mem_addr, mem_dataW, mem_enaR, mem_enaW
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store initiator for a word-addressed synchronous memory,
//               with read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_access_unit_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_READ_WAIT = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b10;

    logic [2:0]  r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_dataw;
    logic        r_mem_enar;
    logic        r_mem_enaw;

    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_mask;
    logic [31:0] w_rep;
    logic [31:0] w_merged;

    assign w_misaligned = (bus.req_size == 2'b11)
                        | ((bus.req_size == C_SZ_HALF) & bus.req_addr[0])
                        | ((bus.req_size == C_SZ_WORD) & (|bus.req_addr[1:0]));

    // Little-endian lane extraction from the word returned by memory
    always_comb begin
        w_byte = bus.mem_data_out[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = bus.mem_data_out[7:0];
            2'd1:    w_byte = bus.mem_data_out[15:8];
            2'd2:    w_byte = bus.mem_data_out[23:16];
            default: w_byte = bus.mem_data_out[31:24];
        endcase
        w_half = r_addr[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
        case (r_size)
            C_SZ_BYTE: w_load_data = r_signed ? {{24{w_byte[7]}}, w_byte}
                                              : {24'd0, w_byte};
            C_SZ_HALF: w_load_data = r_signed ? {{16{w_half[15]}}, w_half}
                                              : {16'd0, w_half};
            default:   w_load_data = bus.mem_data_out;
        endcase
    end

    // Replicate store data across all lanes, then keep only the addressed one
    always_comb begin
        if (r_size == C_SZ_BYTE) begin
            w_mask = 32'h0000_00FF << {r_addr[1:0], 3'b000};
            w_rep  = {4{r_wdata[7:0]}};
        end else begin
            w_mask = 32'h0000_FFFF << {r_addr[1], 4'b0000};
            w_rep  = {2{r_wdata}};
        end
        w_merged = (bus.mem_data_out & ~w_mask) | (w_rep & w_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 16'd0;
            r_err       <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_dataw <= 32'd0;
            r_mem_enar  <= 1'b0;
            r_mem_enaw  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata[15:0];
                        r_err    <= w_misaligned;
                        if (w_misaligned) begin
                            r_rsp_rdata <= 32'd0;
                            r_state     <= S_RESP;
                        end else if (bus.req_write && (bus.req_size == C_SZ_WORD)) begin
                            r_mem_enaw  <= 1'b1;
                            r_mem_addr  <= {2'b00, bus.req_addr[31:2]};
                            r_mem_dataw <= bus.req_wdata;
                            r_state     <= S_WRITE;
                        end else begin
                            r_mem_enar <= 1'b1;
                            r_mem_addr <= {2'b00, bus.req_addr[31:2]};
                            r_state    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_mem_enar <= 1'b0;
                    r_mem_addr <= 32'd0;
                    r_state    <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (r_write) begin
                        r_mem_enaw  <= 1'b1;
                        r_mem_addr  <= {2'b00, r_addr[31:2]};
                        r_mem_dataw <= w_merged;
                        r_state     <= S_WRITE;
                    end else begin
                        r_rsp_rdata <= w_load_data;
                        r_state     <= S_RESP;
                    end
                end
                S_WRITE: begin
                    r_mem_enaw  <= 1'b0;
                    r_mem_addr  <= 32'd0;
                    r_mem_dataw <= 32'd0;
                    r_rsp_rdata <= 32'd0;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall     = (r_state != S_IDLE) && (r_state != S_RESP);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_err   = (r_state == S_RESP) && r_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_dataW = r_mem_dataw;
    assign bus.mem_enaR  = r_mem_enar;
    assign bus.mem_enaW  = r_mem_enaw;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               synchronous-read word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_access_unit_if bus ();
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always @(posedge clk) begin
        if (bus.mem_enaW) mem[bus.mem_addr[5:0]] <= bus.mem_dataW;
        if (bus.mem_enaR) bus.mem_data_out <= mem[bus.mem_addr[5:0]];
    end

    // Issue one request; capture what happens until rsp_valid (or 20 cycles)
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd, output logic er,
                             output int nr, output int nw, output logic [31:0] waddr,
                             output logic [31:0] wdat, output logic proto_ok);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_addr = ~addr; bus.req_wdata = ~wd;
        lat = -1; rd = 32'hX; er = 1'bX; nr = 0; nw = 0;
        waddr = 32'hX; wdat = 32'hX; proto_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_enaR) nr++;
            if (bus.mem_enaW) begin nw++; waddr = bus.mem_addr; wdat = bus.mem_dataW; end
            if (bus.mem_enaR && bus.mem_enaW) proto_ok = 1'b0;
            if (bus.rsp_valid) begin
                lat = c; rd = bus.rsp_rdata; er = bus.rsp_err;
                if (bus.stall) proto_ok = 1'b0;
                break;
            end else if (!bus.stall) proto_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.stall, bus.rsp_valid, bus.rsp_err, bus.mem_enaR, bus.mem_enaW} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.stall, bus.rsp_valid, bus.rsp_err, bus.mem_enaR, bus.mem_enaW});
        else n_pass++;
        n_checks++;
        if ({bus.rsp_rdata, bus.mem_addr, bus.mem_dataW} !== 96'd0)
            $display("FAIL reset_data: rdata=%h addr=%h dataW=%h want 0",
                     bus.rsp_rdata, bus.mem_addr, bus.mem_dataW);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_word();
        int lat, nr, nw; logic [31:0] rd, wa, wdt; logic er, ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nr, nw, wa, wdt, ok);
        n_checks++;
        if (lat !== 2 || nw !== 1 || nr !== 0 || er !== 1'b0)
            $display("FAIL sw_timing: lat=%0d nw=%0d nr=%0d err=%b want 2 1 0 0", lat, nw, nr, er);
        else n_pass++;
        n_checks++;
        if (wa !== 32'd4 || wdt !== 32'hDEADBEEF || rd !== 32'd0 || ok !== 1'b1)
            $display("FAIL sw_bus: addr=%h data=%h rdata=%h proto=%b want 4 deadbeef 0 1",
                     wa, wdt, rd, ok);
        else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nr, nw, wa, wdt, ok);
        n_checks++;
        if (lat !== 3 || nr !== 1 || nw !== 0 || rd !== 32'hDEADBEEF || ok !== 1'b1)
            $display("FAIL lw: lat=%0d nr=%0d nw=%0d rdata=%h proto=%b want 3 1 0 deadbeef 1",
                     lat, nr, nw, rd, ok);
        else n_pass++;
    endtask

    task automatic test_subword_load();
        int lat, nr, nw; logic [31:0] rd, wa, wdt; logic er, ok;
        logic [31:0] addrs [4] = '{32'h0B, 32'h0B, 32'h0A, 32'h08};
        logic [1:0]  szs   [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sgs   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        do_access(1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF7F01, lat, rd, er, nr, nw, wa, wdt, ok);
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, szs[i], sgs[i], addrs[i], 32'h0, lat, rd, er, nr, nw, wa, wdt, ok);
            n_checks++;
            if (lat !== 3 || rd !== exps[i] || er !== 1'b0)
                $display("FAIL subload_%0d: lat=%0d rdata=%h err=%b want 3 %h 0",
                         i, lat, rd, er, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rmw();
        int lat, nr, nw; logic [31:0] rd, wa, wdt; logic er, ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, lat, rd, er, nr, nw, wa, wdt, ok);
        do_access(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB, lat, rd, er, nr, nw, wa, wdt, ok);
        n_checks++;
        if (lat !== 4 || nr !== 1 || nw !== 1 || wa !== 32'd8 || wdt !== 32'h1122AB44
            || rd !== 32'd0 || ok !== 1'b1)
            $display("FAIL sb_rmw: lat=%0d nr=%0d nw=%0d addr=%h data=%h rdata=%h proto=%b want 4 1 1 8 1122ab44 0 1",
                     lat, nr, nw, wa, wdt, rd, ok);
        else n_pass++;
        do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000CAFE, lat, rd, er, nr, nw, wa, wdt, ok);
        n_checks++;
        if (lat !== 4 || nw !== 1 || wdt !== 32'hCAFEAB44)
            $display("FAIL sh_rmw: lat=%0d nw=%0d data=%h want 4 1 cafeab44", lat, nw, wdt);
        else n_pass++;
        n_checks++;
        if (mem[8] !== 32'hCAFEAB44)
            $display("FAIL sh_mem: got %h want cafeab44", mem[8]);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        int lat, nr, nw; logic [31:0] rd, wa, wdt; logic er, ok;
        logic        wrs  [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  szs  [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] adrs [3] = '{32'h13, 32'h05, 32'h20};
        for (int i = 0; i < 3; i++) begin
            do_access(wrs[i], szs[i], 1'b0, adrs[i], 32'h5555AAAA, lat, rd, er, nr, nw, wa, wdt, ok);
            n_checks++;
            if (lat !== 1 || er !== 1'b1 || nr !== 0 || nw !== 0 || rd !== 32'd0)
                $display("FAIL misaligned_%0d: lat=%0d err=%b nr=%0d nw=%0d rdata=%h want 1 1 0 0 0",
                         i, lat, er, nr, nw, rd);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int lat, nr, nw, nresp; logic [31:0] rd, wa, wdt; logic er, ok;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
        bus.req_addr = 32'h21; bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.rsp_valid !== 1'b0)
            $display("FAIL rstmid_idle: stall=%b rsp_valid=%b want 0 0", bus.stall, bus.rsp_valid);
        else n_pass++;
        nw = 0; nresp = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.mem_enaW) nw++;
            if (bus.rsp_valid) nresp++;
            @(negedge clk);
        end
        n_checks++;
        if (nw !== 0 || nresp !== 0)
            $display("FAIL rstmid_quiet: enaW=%0d rsp=%0d want 0 0", nw, nresp);
        else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, nr, nw, wa, wdt, ok);
        n_checks++;
        if (rd !== 32'hCAFEAB44)
            $display("FAIL rstmid_mem: got %h want cafeab44", rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nw;
        logic [31:0] w0, w1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h30; bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req_addr = 32'h34; bus.req_wdata = 32'h9ABCDEF0;
        @(negedge clk);
        n_checks++;
        if (bus.mem_enaW !== 1'b1 || bus.mem_addr !== 32'd12 || bus.mem_dataW !== 32'h12345678)
            $display("FAIL b2b_first: enaW=%b addr=%h data=%h want 1 c 12345678",
                     bus.mem_enaW, bus.mem_addr, bus.mem_dataW);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.mem_enaW !== 1'b0)
            $display("FAIL b2b_resp: rsp_valid=%b enaW=%b want 1 0", bus.rsp_valid, bus.mem_enaW);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.mem_enaW !== 1'b0)
            $display("FAIL b2b_gap: stall=%b rsp_valid=%b enaW=%b want 0 0 0",
                     bus.stall, bus.rsp_valid, bus.mem_enaW);
        else n_pass++;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mem_enaW !== 1'b1 || bus.mem_addr !== 32'd13 || bus.mem_dataW !== 32'h9ABCDEF0)
            $display("FAIL b2b_second: enaW=%b addr=%h data=%h want 1 d 9abcdef0",
                     bus.mem_enaW, bus.mem_addr, bus.mem_dataW);
        else n_pass++;
        nw = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.mem_enaW) nw++;
        end
        w0 = mem[12]; w1 = mem[13];
        n_checks++;
        if (nw !== 0 || w0 !== 32'h12345678 || w1 !== 32'h9ABCDEF0)
            $display("FAIL b2b_mem: extra_enaW=%0d w12=%h w13=%h want 0 12345678 9abcdef0",
                     nw, w0, w1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_rmw();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
